// File: rtl/escalonador_varredura_display_pkg.sv
// escalonador_varredura_display_pkg: FSM states, digit indices and anode helpers for the display scan
package escalonador_varredura_display_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_DEAD, ST_ON} estado_t;

    localparam logic [1:0] DIG_VAZ_UNI = 2'd0;
    localparam logic [1:0] DIG_VAZ_DEZ = 2'd1;
    localparam logic [1:0] DIG_OCU_UNI = 2'd2;
    localparam logic [1:0] DIG_OCU_DEZ = 2'd3;

    function automatic logic [3:0] anodos_off(input logic active_low);
        return active_low ? 4'hF : 4'h0;
    endfunction

    function automatic logic [3:0] anodo_on(input logic [1:0] slot, input logic active_low);
        logic [3:0] m;
        m = 4'b0001 << slot;
        return active_low ? ~m : m;
    endfunction

endpackage

// File: rtl/escalonador_varredura_display_conversor_bin_bcd_4bits.sv
// conversor_bin_bcd_4bits: splits a 0-15 value into decimal tens and units
module conversor_bin_bcd_4bits (
    input  logic [3:0] i_valor,
    output logic [3:0] o_dezena,
    output logic [3:0] o_unidade
);

    assign o_dezena  = {3'b000, i_valor >= 4'd10};
    assign o_unidade = (i_valor >= 4'd10) ? i_valor - 4'd10 : i_valor;

endmodule

// File: rtl/escalonador_varredura_display.sv
// escalonador_varredura_display: 4-digit multiplexed display scan with dead time, zero suppression and full-lot blink
module escalonador_varredura_display
    import escalonador_varredura_display_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [3:0] i_ocupados,
    input  logic [3:0] i_vazios,
    output logic [3:0] o_valor,
    output logic [3:0] o_digito_aceso,
    output logic       o_blank,
    output logic       o_frame_start
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = $clog2(2 * BLINK_FRAMES);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(2 * BLINK_FRAMES - 1);
    localparam logic [FW-1:0] BLINK_OFF  = FW'(BLINK_FRAMES);
    localparam logic [3:0]    ALL_OFF    = anodos_off(ACTIVE_LOW);

    estado_t       r_estado, w_estado_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_slot, w_slot_nxt;
    logic [FW-1:0] r_frame;
    logic [3:0]    r_ocu, r_vaz, w_ocu, w_vaz;
    logic          r_pisca_off, w_pisca_off;
    logic [3:0]    w_ocu_dez, w_ocu_uni, w_vaz_dez, w_vaz_uni, w_digito;
    logic          w_latch, w_apagado, w_aceso;

    // LATCH doubles as the first dead cycle of slot 0, so it starts the count at 0
    always_comb begin
        w_estado_nxt = r_estado;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_slot_nxt   = r_slot;
        if (!i_enable) begin
            w_estado_nxt = ST_IDLE;
            w_cnt_nxt    = '0;
            w_slot_nxt   = '0;
        end else begin
            case (r_estado)
                ST_IDLE: begin
                    w_estado_nxt = ST_LATCH;
                    w_cnt_nxt    = '0;
                end
                ST_LATCH: w_estado_nxt = (DEAD_CYCLES > 1) ? ST_DEAD : ST_ON;
                ST_DEAD:  w_estado_nxt = (r_cnt == DEAD_LAST) ? ST_ON : ST_DEAD;
                default: if (r_cnt == SLOT_LAST) begin
                    w_cnt_nxt    = '0;
                    w_slot_nxt   = r_slot + 1'b1;
                    w_estado_nxt = (r_slot == DIG_OCU_DEZ) ? ST_LATCH : ST_DEAD;
                end
            endcase
        end
    end

    // Outputs are computed from next-state values so the registered outputs line up with the state
    assign w_latch     = w_estado_nxt == ST_LATCH;
    assign w_ocu       = w_latch ? i_ocupados : r_ocu;
    assign w_vaz       = w_latch ? i_vazios : r_vaz;
    assign w_pisca_off = w_latch ? (r_frame >= BLINK_OFF) : r_pisca_off;

    conversor_bin_bcd_4bits u_conv_ocu (.i_valor(w_ocu), .o_dezena(w_ocu_dez), .o_unidade(w_ocu_uni));
    conversor_bin_bcd_4bits u_conv_vaz (.i_valor(w_vaz), .o_dezena(w_vaz_dez), .o_unidade(w_vaz_uni));

    assign w_digito = (w_slot_nxt == DIG_OCU_DEZ) ? w_ocu_dez :
                      (w_slot_nxt == DIG_OCU_UNI) ? w_ocu_uni :
                      (w_slot_nxt == DIG_VAZ_DEZ) ? w_vaz_dez : w_vaz_uni;
    assign w_apagado = (w_slot_nxt == DIG_OCU_DEZ && w_ocu_dez == 4'd0) ||
                       (w_slot_nxt == DIG_VAZ_DEZ && w_vaz_dez == 4'd0) ||
                       (!w_slot_nxt[1] && w_vaz == 4'd0 && w_pisca_off);
    assign w_aceso   = (w_estado_nxt == ST_ON) && !w_apagado;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado       <= ST_IDLE;
            r_cnt          <= '0;
            r_slot         <= '0;
            r_frame        <= '0;
            r_ocu          <= '0;
            r_vaz          <= '0;
            r_pisca_off    <= 1'b0;
            o_valor        <= '0;
            o_digito_aceso <= ALL_OFF;
            o_blank        <= 1'b1;
            o_frame_start  <= 1'b0;
        end else begin
            r_estado       <= w_estado_nxt;
            r_cnt          <= w_cnt_nxt;
            r_slot         <= w_slot_nxt;
            r_frame        <= w_latch ? ((r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1) : r_frame;
            r_ocu          <= w_ocu;
            r_vaz          <= w_vaz;
            r_pisca_off    <= w_pisca_off;
            o_valor        <= (w_estado_nxt == ST_IDLE) ? 4'd0 : w_digito;
            o_digito_aceso <= w_aceso ? anodo_on(w_slot_nxt, ACTIVE_LOW) : ALL_OFF;
            o_blank        <= !w_aceso;
            o_frame_start  <= w_latch;
        end
    end

endmodule

// File: tb/tb_escalonador_varredura_display.sv
// tb_escalonador_varredura_display: directed scenarios for the display scan scheduler (CLK_DIV=8, DEAD=2, BLINK=2)
module tb_escalonador_varredura_display;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [3:0] ocu = 4'd12, vaz = 4'd3;
    logic [3:0] valor, an;
    logic       blank, fs;
    int         total = 0, bad = 0;

    logic [3:0] cap_an[32], cap_val[32];
    logic       cap_fs[32];
    int         sv_val[4], sv_lit[4], sv_first[4], sv_stable[4];
    int         sv_wrong, sv_fs_in;
    logic       fs_next;

    always #5 clk = ~clk;

    escalonador_varredura_display #(
        .CLK_DIV(8), .DEAD_CYCLES(2), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_ocupados(ocu), .i_vazios(vaz),
        .o_valor(valor), .o_digito_aceso(an), .o_blank(blank), .o_frame_start(fs)
    );

    // At most one anode lit, and all anodes off exactly when Blank is high
    always @(negedge clk) begin
        total++;
        if (!((an === 4'hF && blank === 1'b1) || ($countones(~an) == 1 && blank === 1'b0))) begin
            bad++;
            $display("FAIL anode_onehot an=%b blank=%b", an, blank);
        end
    end

    task automatic wait_frame();
        int n = 0;
        while (fs !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (fs !== 1'b1) begin
            bad++;
            $display("FAIL wait_frame timeout fs=%b exp=1", fs);
        end
    endtask

    // Record one frame starting at a FrameStart sample and summarise each slot
    task automatic capture_frame(input int chg_cyc, input logic [3:0] chg_ocu);
        logic [3:0] pat;
        for (int i = 0; i < 32; i++) begin
            cap_an[i] = an;
            cap_val[i] = valor;
            cap_fs[i] = fs;
            if (i == chg_cyc) ocu = chg_ocu;
            @(negedge clk);
        end
        fs_next = fs;
        sv_wrong = 0;
        sv_fs_in = 0;
        for (int i = 1; i < 32; i++) sv_fs_in += int'(cap_fs[i]);
        for (int s = 0; s < 4; s++) begin
            pat = ~(4'b0001 << s);
            sv_val[s] = int'(cap_val[s*8]);
            sv_lit[s] = 0;
            sv_first[s] = -1;
            sv_stable[s] = 1;
            for (int c = 0; c < 8; c++) begin
                if (cap_an[s*8+c] === pat) begin
                    sv_lit[s]++;
                    if (sv_first[s] < 0) sv_first[s] = c;
                end else if (cap_an[s*8+c] !== 4'hF) sv_wrong++;
                if (cap_val[s*8+c] !== cap_val[s*8]) sv_stable[s] = 0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'hF || blank !== 1'b1 || valor !== 4'd0 || fs !== 1'b0) begin
            bad++;
            $display("FAIL reset_values an=%b blank=%b valor=%0d fs=%b exp 1111/1/0/0", an, blank, valor, fs);
        end
        rst = 1'b0;
        en = 1'b1;
        @(negedge clk);
        total++;
        if (fs !== 1'b1) begin bad++; $display("FAIL reset_release_fs got=%b exp=1", fs); end
        repeat (4) @(negedge clk);
        total++;
        if (an !== 4'b1110 || valor !== 4'd3) begin
            bad++;
            $display("FAIL reset_pre_on an=%b valor=%0d exp 1110/3", an, valor);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (an !== 4'hF || blank !== 1'b1 || valor !== 4'd0) begin
            bad++;
            $display("FAIL reset_async an=%b blank=%b valor=%0d exp 1111/1/0", an, blank, valor);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (fs !== 1'b1) begin bad++; $display("FAIL reset_relatch_fs got=%b exp=1", fs); end
    endtask

    task automatic test_scan();
        int ev[4] = '{3, 0, 2, 1};
        int el[4] = '{6, 0, 6, 6};
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 4'd0);
            for (int s = 0; s < 4; s++) begin
                total++;
                if (sv_lit[s] !== el[s]) begin bad++; $display("FAIL scan f%0d slot%0d lit=%0d exp=%0d", f, s, sv_lit[s], el[s]); end
                if (el[s] > 0) begin
                    total++;
                    if (sv_val[s] !== ev[s] || sv_first[s] !== 2 || sv_stable[s] !== 1) begin
                        bad++;
                        $display("FAIL scan f%0d slot%0d valor=%0d exp=%0d first=%0d exp=2 stable=%0d", f, s, sv_val[s], ev[s], sv_first[s], sv_stable[s]);
                    end
                end
            end
            total++;
            if (sv_wrong !== 0 || sv_fs_in !== 0 || fs_next !== 1'b1 || cap_fs[0] !== 1'b1) begin
                bad++;
                $display("FAIL scan f%0d frame wrong=%0d extra_fs=%0d fs0=%b fs32=%b exp 0/0/1/1", f, sv_wrong, sv_fs_in, cap_fs[0], fs_next);
            end
        end
    endtask

    task automatic test_snapshot();
        int ev[2][4] = '{'{3, 0, 2, 1}, '{3, 0, 7, 0}};
        int el[2][4] = '{'{6, 0, 6, 6}, '{6, 0, 6, 0}};
        for (int f = 0; f < 2; f++) begin
            capture_frame(f == 0 ? 10 : -1, 4'd7);
            for (int s = 0; s < 4; s++) begin
                total++;
                if (sv_lit[s] !== el[f][s]) begin bad++; $display("FAIL snapshot f%0d slot%0d lit=%0d exp=%0d", f, s, sv_lit[s], el[f][s]); end
                if (el[f][s] > 0) begin
                    total++;
                    if (sv_val[s] !== ev[f][s]) begin bad++; $display("FAIL snapshot f%0d slot%0d valor=%0d exp=%0d", f, s, sv_val[s], ev[f][s]); end
                end
            end
            total++;
            if (sv_wrong !== 0 || fs_next !== 1'b1) begin bad++; $display("FAIL snapshot f%0d frame wrong=%0d fs32=%b exp 0/1", f, sv_wrong, fs_next); end
        end
    endtask

    task automatic test_full_blink();
        int ev[4] = '{0, 0, 5, 1};
        int el[4];
        @(negedge clk);
        rst = 1'b1;
        ocu = 4'd15;
        vaz = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        wait_frame();
        for (int f = 0; f < 5; f++) begin
            el = '{(f == 2 || f == 3) ? 0 : 6, 0, 6, 6};
            capture_frame(-1, 4'd15);
            for (int s = 0; s < 4; s++) begin
                total++;
                if (sv_lit[s] !== el[s]) begin bad++; $display("FAIL blink f%0d slot%0d lit=%0d exp=%0d", f, s, sv_lit[s], el[s]); end
                if (el[s] > 0) begin
                    total++;
                    if (sv_val[s] !== ev[s] || sv_first[s] !== 2) begin
                        bad++;
                        $display("FAIL blink f%0d slot%0d valor=%0d exp=%0d first=%0d exp=2", f, s, sv_val[s], ev[s], sv_first[s]);
                    end
                end
            end
            total++;
            if (sv_wrong !== 0 || sv_fs_in !== 0 || fs_next !== 1'b1) begin
                bad++;
                $display("FAIL blink f%0d frame wrong=%0d extra_fs=%0d fs32=%b exp 0/0/1", f, sv_wrong, sv_fs_in, fs_next);
            end
        end
    endtask

    task automatic test_enable_drop();
        repeat (20) @(negedge clk);
        total++;
        if (an !== 4'b1011 || valor !== 4'd5) begin bad++; $display("FAIL endrop_slot2 an=%b valor=%0d exp 1011/5", an, valor); end
        en = 1'b0;
        vaz = 4'd3;
        ocu = 4'd12;
        @(negedge clk);
        total++;
        if (an !== 4'hF || blank !== 1'b1) begin bad++; $display("FAIL endrop_off an=%b blank=%b exp 1111/1", an, blank); end
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'hF || blank !== 1'b1 || fs !== 1'b0) begin
            bad++;
            $display("FAIL endrop_idle an=%b blank=%b fs=%b exp 1111/1/0", an, blank, fs);
        end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (fs !== 1'b1 || an !== 4'hF) begin bad++; $display("FAIL endrop_relatch fs=%b an=%b exp 1/1111", fs, an); end
        @(negedge clk);
        total++;
        if (an !== 4'hF || fs !== 1'b0) begin bad++; $display("FAIL endrop_dead an=%b fs=%b exp 1111/0", an, fs); end
        @(negedge clk);
        total++;
        if (an !== 4'b1110 || valor !== 4'd3) begin bad++; $display("FAIL endrop_slot0 an=%b valor=%0d exp 1110/3", an, valor); end
    endtask

    task automatic test_boundaries();
        int ev[3][4] = '{'{3, 0, 0, 1}, '{3, 0, 9, 0}, '{3, 0, 0, 0}};
        int el[3][4] = '{'{6, 0, 6, 6}, '{6, 0, 6, 0}, '{6, 0, 6, 0}};
        int cc[3] = '{5, 5, -1};
        logic [3:0] cv[3] = '{4'd9, 4'd0, 4'd0};
        ocu = 4'd10;
        wait_frame();
        for (int f = 0; f < 3; f++) begin
            capture_frame(cc[f], cv[f]);
            for (int s = 0; s < 4; s++) begin
                total++;
                if (sv_lit[s] !== el[f][s]) begin bad++; $display("FAIL bound f%0d slot%0d lit=%0d exp=%0d", f, s, sv_lit[s], el[f][s]); end
                if (el[f][s] > 0) begin
                    total++;
                    if (sv_val[s] !== ev[f][s] || sv_first[s] !== 2) begin
                        bad++;
                        $display("FAIL bound f%0d slot%0d valor=%0d exp=%0d first=%0d exp=2", f, s, sv_val[s], ev[f][s], sv_first[s]);
                    end
                end
            end
            total++;
            if (sv_wrong !== 0 || fs_next !== 1'b1) begin bad++; $display("FAIL bound f%0d frame wrong=%0d fs32=%b exp 0/1", f, sv_wrong, fs_next); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_full_blink();
        test_enable_drop();
        test_boundaries();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
